// File: rtl/adaptive_filter_pkg.sv
// Shared constants, state encoding and flattened-bus helpers for the adaptive filter.
package adaptive_filter_pkg;

    localparam int unsigned NTAPS   = 32;
    localparam int unsigned W_W     = 32;
    localparam int unsigned R_W     = 14;
    localparam int unsigned Y_SHIFT = 18;
    localparam int unsigned IDX_W   = $clog2(NTAPS);
    localparam int unsigned P_W     = W_W + R_W;
    localparam int unsigned ACC_W   = W_W + R_W + $clog2(NTAPS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [W_W-1:0] weight_tap(input logic [NTAPS*W_W-1:0] bus,
                                                  input logic [IDX_W-1:0]     i);
        return bus[32'(i) * W_W +: W_W];
    endfunction

    function automatic logic [R_W-1:0] reff_tap(input logic [NTAPS*R_W-1:0] bus,
                                                input logic [IDX_W-1:0]     i);
        return bus[32'(i) * R_W +: R_W];
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Unsigned multiply-accumulate with synchronous clear and enable.
module fir_mac_unit
    import adaptive_filter_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             en,
    input  logic [W_W-1:0]   w,
    input  logic [R_W-1:0]   r,
    output logic [ACC_W-1:0] acc
);

    logic [P_W-1:0] prod;

    assign prod = P_W'(w) * P_W'(r);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/fir_tap_mac_reader.sv
// Evaluates y = sum(w_i * reff_i) >> Y_SHIFT with one shared MAC, then |d - y| and its sign.
module fir_tap_mac_reader
    import adaptive_filter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [R_W-1:0]       d,
    input  logic [NTAPS*W_W-1:0] weight_bus,
    input  logic [NTAPS*R_W-1:0] reff_bus,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [R_W-1:0]       y,
    output logic [R_W-1:0]       e,
    output logic                 e_neg
);

    localparam logic [ACC_W-1:0] Y_MAX = ACC_W'((1 << R_W) - 1);

    state_t           state, state_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic [R_W-1:0]   d_reg, d_nx;
    logic             mac_clr, mac_en, res_ld;
    logic [ACC_W-1:0] acc, acc_sh;
    logic [R_W-1:0]   y_sat, e_mag;
    logic             y_gt_d;

    fir_mac_unit u_mac (
        .clk  (clk),
        .rstn (rstn),
        .clr  (mac_clr),
        .en   (mac_en),
        .w    (weight_tap(weight_bus, idx)),
        .r    (reff_tap(reff_bus, idx)),
        .acc  (acc)
    );

    // Scale, saturate and form the error from the completed accumulation
    always_comb begin
        acc_sh = acc >> Y_SHIFT;
        y_sat  = (acc_sh > Y_MAX) ? '1 : acc_sh[R_W-1:0];
        y_gt_d = (y_sat > d_reg);
        e_mag  = y_gt_d ? (y_sat - d_reg) : (d_reg - y_sat);
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        d_nx     = d_reg;
        mac_clr  = 1'b0;
        mac_en   = 1'b0;
        res_ld   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_MAC;
                    idx_nx   = '0;
                    d_nx     = d;
                    mac_clr  = 1'b1;
                end
            end
            ST_MAC: begin
                mac_en = 1'b1;
                if (idx == IDX_W'(NTAPS - 1)) begin
                    state_nx = ST_FINAL;
                    idx_nx   = '0;
                end else begin
                    idx_nx = idx + IDX_W'(1);
                end
            end
            ST_FINAL: begin
                res_ld   = 1'b1;
                state_nx = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            idx       <= '0;
            d_reg     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            y         <= '0;
            e         <= '0;
            e_neg     <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            d_reg     <= d_nx;
            busy      <= (state_nx == ST_MAC) || (state_nx == ST_FINAL);
            out_valid <= (state_nx == ST_DONE);
            if (res_ld) begin
                y     <= y_sat;
                e     <= e_mag;
                e_neg <= y_gt_d;
            end
        end
    end

endmodule

// File: tb/tb_fir_tap_mac_reader.sv
// Randomized and directed checks of fir_tap_mac_reader against an arithmetic reference.
module tb_fir_tap_mac_reader;
    import adaptive_filter_pkg::*;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 start = 1'b0;
    logic [R_W-1:0]       d = '0;
    logic [NTAPS*W_W-1:0] weight_bus = '0;
    logic [NTAPS*R_W-1:0] reff_bus = '0;
    logic                 busy, out_valid, e_neg;
    logic                 out_ready = 1'b0;
    logic [R_W-1:0]       y, e;

    int checks = 0;
    int errors = 0;

    fir_tap_mac_reader dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .d          (d),
        .weight_bus (weight_bus),
        .reff_bus   (reff_bus),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y),
        .e          (e),
        .e_neg      (e_neg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [W_W-1:0] wv, input logic [R_W-1:0] rv);
        for (int i = 0; i < NTAPS; i++) begin
            weight_bus[i*W_W +: W_W] = wv;
            reff_bus[i*R_W +: R_W]   = rv;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NTAPS; i++) begin
            weight_bus[i*W_W +: W_W] = W_W'($urandom >> $urandom_range(0, 31));
            reff_bus[i*R_W +: R_W]   = R_W'($urandom_range(0, 16383));
        end
    endtask

    // Reference: full-precision dot product, scaled, clamped, then distance to d
    task automatic model(input logic [R_W-1:0] dv, output logic [R_W-1:0] ym,
                         output logic [R_W-1:0] em, output logic nm);
        longint unsigned sum = 0;
        longint unsigned ys;
        for (int i = 0; i < NTAPS; i++)
            sum += longint'(weight_bus[i*W_W +: W_W]) * longint'(reff_bus[i*R_W +: R_W]);
        ys = sum / (64'd1 << Y_SHIFT);
        ym = (ys > 64'd16383) ? 14'h3fff : R_W'(ys);
        nm = (int'(ym) > int'(dv));
        em = nm ? R_W'(int'(ym) - int'(dv)) : R_W'(int'(dv) - int'(ym));
    endtask

    task automatic run_case(input string tag, input logic [R_W-1:0] dv, input bit poke);
        logic [R_W-1:0] ym, em;
        logic           nm;
        int             cnt = 0;
        model(dv, ym, em, nm);
        @(negedge clk);
        start = 1'b1; d = dv; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; d = ~dv;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        while (cnt < 100) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            start = poke && (cnt == 5 || cnt == 20);
            if (out_valid) break;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(cnt), 64'd33);
        check({tag, "_y"}, 64'(y), 64'(ym));
        check({tag, "_e"}, 64'(e), 64'(em));
        check({tag, "_eneg"}, 64'(e_neg), 64'(nm));
        for (int k = 0; k < 5; k++) begin
            start = poke;
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_y"}, {49'd0, e_neg, y}, {49'd0, nm, ym});
            check({tag, "_hold_e"}, 64'(e), 64'(em));
        end
        out_ready = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0; start = 1'b0;
        check({tag, "_release_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_release_busy"}, 64'(busy), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_idle_y"}, 64'(y), 64'(ym));
    endtask

    initial begin
        int seen;
        #12;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_y", 64'(y), 64'd0);
        check("rst_e", 64'(e), 64'd0);
        check("rst_eneg", 64'(e_neg), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < NTAPS; i++) reff_bus[i*R_W +: R_W] = R_W'($urandom);
        weight_bus = '0;
        run_case("zero_w", 14'd100, 1'b0);
        check("zero_w_e_abs", 64'(e), 64'd100);

        fill(32'h0004_0000, 14'd1);
        run_case("unit_d100", 14'd100, 1'b1);
        check("unit_d100_y_abs", 64'(y), 64'd32);
        check("unit_d100_e_abs", 64'(e), 64'd68);

        run_case("unit_d10", 14'd10, 1'b0);
        check("unit_d10_e_abs", {49'd0, e_neg, e}, {49'd0, 1'b1, 14'd22});

        fill(32'hffff_ffff, 14'h3fff);
        run_case("sat", 14'd0, 1'b1);
        check("sat_y_abs", 64'(y), 64'h3fff);

        for (int t = 0; t < 8; t++) begin
            fill_random();
            run_case($sformatf("rand%0d", t), R_W'($urandom), t[0]);
        end

        // Reset in the middle of an evaluation discards it
        fill(32'h0004_0000, 14'd1);
        @(negedge clk);
        start = 1'b1; d = 14'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_out", {48'd0, e_neg, y, e}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        check("midrst_no_valid", 64'(seen), 64'd0);

        fill(32'h0004_0000, 14'd2);
        run_case("recover", 14'd64, 1'b0);
        check("recover_y_abs", {49'd0, e_neg, y}, {49'd0, 1'b0, 14'd64});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
